crc_stream_engine: RTL and testbench

Parametrised CRC-W generator/checker. It takes a stream of DATA_W-bit words over a valid/ready handshake and computes an MSB-first (non-reflected) CRC with configurable polynomial, initial value and final XOR. Per frame, it either streams the CRC out one bit at a time over a second handshake for appending to a serial link, or flags a residue match for receive-side checking. It is the successor to the fixed 16-bit single-bit serial CRC block and sits between the serial framer and the link shifter.

---
 rtl/crc_pkg.sv | 34 +++
 rtl/crc_step_comb.sv | 27 ++
 rtl/crc_stream_engine.sv | 121 ++++++++++++
 tb/tb_crc_stream_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types, polynomial presets and the single-bit CRC step for the CRC stream engine family.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CALC      = 2'd1,
      SHIFT_OUT = 2'd2
   } crc_state_t;

   // CRC-16/CDMA2000
   localparam logic [15:0] CDMA2000_POLY = 16'hC867;
   localparam logic [15:0] CDMA2000_INIT = 16'hFFFF;
   localparam logic [15:0] CDMA2000_XOR  = 16'h0000;

   // CRC-16/XMODEM
   localparam logic [15:0] XMODEM_POLY = 16'h1021;
   localparam logic [15:0] XMODEM_INIT = 16'h0000;
   localparam logic [15:0] XMODEM_XOR  = 16'h0000;

   // One MSB-first step of the direct (non-augmented) algorithm. Values are
   // carried zero-extended to 32 bits; msb is the index of the CRC's top bit.
   // Bits above msb in the result are garbage and must be truncated by the caller.
   function automatic logic [31:0] crc_bit_step(input logic [31:0] crc,
                                                input logic        b,
                                                input logic [31:0] poly,
                                                input logic [4:0]  msb);
      logic fb;
      fb = crc[msb] ^ b;
      return (crc << 1) ^ (fb ? poly : 32'd0);
   endfunction

endpackage

// File: rtl/crc_step_comb.sv
// Combinational CRC advance over one DATA_W-bit word, MSB of the word first.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when to register crc_next.
// Ports: crc (current remainder), data (input word), crc_next (remainder after all DATA_W bits).
module crc_step_comb
   import crc_pkg::*;
#(
   parameter int                 CRC_W  = 16,
   parameter int                 DATA_W = 8,
   parameter logic [CRC_W-1:0]   POLY   = CRC_W'(CDMA2000_POLY)
) (
   input  logic [CRC_W-1:0]  crc,
   input  logic [DATA_W-1:0] data,
   output logic [CRC_W-1:0]  crc_next
);

   localparam logic [4:0] MSB = 5'(CRC_W - 1);

   // All DATA_W bit steps unrolled into one cone of logic.
   always_comb begin
      crc_next = crc;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         crc_next = CRC_W'(crc_bit_step(32'(crc_next), data[i], 32'(POLY), MSB));
      end
   end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed CRC generator/checker: accumulates DATA_W-bit beats, then streams the CRC serially or flags a residue match.
// Latency: last beat to DONE/CRC_VALUE is 1 cycle; first serial CRC bit is presented the cycle after DONE.
// Backpressure: IN_READY low outside CALC and while START is high; OUT_READY low holds CRC_BIT/OUT_LAST stable.
// Ports: CLK/RESET (async, active-high); START/APPEND open a frame; DATA_IN/IN_VALID/IN_LAST/IN_READY input beats;
//        CRC_BIT/OUT_VALID/OUT_READY/OUT_LAST serial CRC out; CRC_VALUE/CHECK_OK/DONE frame-end results.
module crc_stream_engine
   import crc_pkg::*;
#(
   parameter int               CRC_W   = 16,
   parameter int               DATA_W  = 8,
   parameter logic [CRC_W-1:0] POLY    = CRC_W'(CDMA2000_POLY),
   parameter logic [CRC_W-1:0] INIT    = CRC_W'(CDMA2000_INIT),
   parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(CDMA2000_XOR),
   parameter logic [CRC_W-1:0] RESIDUE = '0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              APPEND,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              IN_VALID,
   input  logic              IN_LAST,
   output logic              IN_READY,
   output logic              CRC_BIT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              OUT_LAST,
   output logic [CRC_W-1:0]  CRC_VALUE,
   output logic              CHECK_OK,
   output logic              DONE
);

   localparam int               CNT_W    = $clog2(CRC_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CRC_W - 1);

   crc_state_t       state, state_nxt;
   logic [CRC_W-1:0] crc_reg, crc_next, out_sr;
   logic [CNT_W-1:0] bit_cnt;
   logic             append_q, done_q;
   logic             beat_acc, last_acc, bit_acc, final_bit;

   crc_step_comb #(
      .CRC_W  (CRC_W),
      .DATA_W (DATA_W),
      .POLY   (POLY)
   ) u_step (
      .crc      (crc_reg),
      .data     (DATA_IN),
      .crc_next (crc_next)
   );

   // START wins over a same-cycle beat, so it is folded into acceptance.
   assign beat_acc  = (state == CALC) && IN_VALID && !START;
   assign last_acc  = beat_acc && IN_LAST;
   assign bit_acc   = OUT_VALID && OUT_READY;
   assign final_bit = bit_acc && (bit_cnt == LAST_BIT);

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (START) begin
         state_nxt = CALC;
      end else begin
         case (state)
            CALC:      if (last_acc)  state_nxt = append_q ? SHIFT_OUT : IDLE;
            SHIFT_OUT: if (final_bit) state_nxt = IDLE;
            default:   state_nxt = state;
         endcase
      end
   end

   // Output logic: registered state only, plus START for IN_READY.
   // The DONE cycle is spent in SHIFT_OUT with OUT_VALID held off so the
   // first bit lands one cycle after DONE.
   always_comb begin
      IN_READY  = (state == CALC) && !START;
      OUT_VALID = (state == SHIFT_OUT) && !done_q;
      CRC_BIT   = (state == SHIFT_OUT) && !done_q && out_sr[CRC_W-1];
      OUT_LAST  = (state == SHIFT_OUT) && !done_q && (bit_cnt == LAST_BIT);
      DONE      = done_q;
   end

   // Datapath registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         crc_reg   <= INIT;
         append_q  <= 1'b0;
         out_sr    <= '0;
         bit_cnt   <= '0;
         done_q    <= 1'b0;
         CRC_VALUE <= '0;
         CHECK_OK  <= 1'b0;
      end else begin
         done_q <= last_acc;
         if (START) begin
            crc_reg  <= INIT;
            append_q <= APPEND;
            out_sr   <= '0;
            bit_cnt  <= '0;
         end else begin
            if (beat_acc) crc_reg <= crc_next;
            if (last_acc) begin
               CRC_VALUE <= crc_next ^ XOR_OUT;
               CHECK_OK  <= (crc_next == RESIDUE);
               out_sr    <= crc_next ^ XOR_OUT;
               bit_cnt   <= '0;
            end else if (bit_acc) begin
               out_sr  <= {out_sr[CRC_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: CDMA2000 and XMODEM byte-wide instances share stimulus,
// plus a bit-serial (DATA_W=1) instance. Expected CRCs come from a polynomial long-division model.
// Bench only; not for synthesis.
module tb_crc_stream_engine;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, append, in_vld, in_last, out_rdy;
   logic [7:0]  data;
   logic        a_in_rdy, a_bit, a_out_vld, a_out_last, a_ok, a_done;
   logic [15:0] a_crc;
   logic        b_in_rdy, b_bit, b_out_vld, b_out_last, b_ok, b_done;
   logic [15:0] b_crc;
   logic        c_start, c_append, c_vld, c_last, c_out_rdy;
   logic [0:0]  c_data;
   logic        c_in_rdy, c_bit, c_out_vld, c_out_last, c_ok, c_done;
   logic [15:0] c_crc;

   int n_chk = 0;
   int n_err = 0;

   crc_stream_engine dut_a (
      .CLK(clk), .RESET(rst), .START(start), .APPEND(append), .DATA_IN(data),
      .IN_VALID(in_vld), .IN_LAST(in_last), .IN_READY(a_in_rdy), .CRC_BIT(a_bit),
      .OUT_VALID(a_out_vld), .OUT_READY(out_rdy), .OUT_LAST(a_out_last),
      .CRC_VALUE(a_crc), .CHECK_OK(a_ok), .DONE(a_done));

   crc_stream_engine #(.POLY(16'h1021), .INIT(16'h0000)) dut_b (
      .CLK(clk), .RESET(rst), .START(start), .APPEND(append), .DATA_IN(data),
      .IN_VALID(in_vld), .IN_LAST(in_last), .IN_READY(b_in_rdy), .CRC_BIT(b_bit),
      .OUT_VALID(b_out_vld), .OUT_READY(out_rdy), .OUT_LAST(b_out_last),
      .CRC_VALUE(b_crc), .CHECK_OK(b_ok), .DONE(b_done));

   crc_stream_engine #(.DATA_W(1)) dut_c (
      .CLK(clk), .RESET(rst), .START(c_start), .APPEND(c_append), .DATA_IN(c_data),
      .IN_VALID(c_vld), .IN_LAST(c_last), .IN_READY(c_in_rdy), .CRC_BIT(c_bit),
      .OUT_VALID(c_out_vld), .OUT_READY(c_out_rdy), .OUT_LAST(c_out_last),
      .CRC_VALUE(c_crc), .CHECK_OK(c_ok), .DONE(c_done));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Remainder of the message treated as a polynomial: the register seed is
   // folded into the first 16 message bits, the message is multiplied by x^16,
   // and divided by x^16 + poly by long division. Needs >= 2 bytes.
   function automatic logic [15:0] ref_rem(input logic [7:0] msg[$],
                                           input logic [15:0] poly,
                                           input logic [15:0] init);
      bit d[$];
      int n;
      logic [15:0] r;
      foreach (msg[i]) for (int k = 7; k >= 0; k--) d.push_back(msg[i][k]);
      n = d.size();
      for (int i = 0; i < 16; i++) d[i] = d[i] ^ init[15-i];
      for (int i = 0; i < 16; i++) d.push_back(1'b0);
      for (int i = 0; i < n; i++)
         if (d[i]) for (int j = 0; j < 16; j++) d[i+1+j] = d[i+1+j] ^ poly[15-j];
      r = '0;
      for (int j = 0; j < 16; j++) r[15-j] = d[n+j];
      return r;
   endfunction

   task automatic pulse_start(input bit app, input bit with_beat);
      @(negedge clk);
      start = 1; append = app; in_vld = with_beat; in_last = with_beat; data = 8'($urandom);
      #1 check_val("in_rdy_during_start", a_in_rdy, 0);
      @(posedge clk);
   endtask

   task automatic feed(input logic [7:0] msg[$], input int gap_pct, input int n_beats);
      int dones;
      bit sent;
      int tries;
      dones = 0;
      for (int i = 0; i < n_beats; i++) begin
         sent = 0; tries = 0;
         while (!sent) begin
            @(negedge clk);
            start = 0;
            dones += int'(a_done);
            in_vld = ($urandom_range(0, 99) >= gap_pct) || (tries >= 8);
            tries++;
            data = msg[i];
            in_last = (i == msg.size() - 1);
            #1;
            if (in_vld) begin
               check_val("in_rdy", a_in_rdy, 1);
               sent = 1;
            end
            @(posedge clk);
         end
      end
      check_val("no_done_before_end", dones, 0);
   endtask

   task automatic end_check(input logic [15:0] ea, input logic [15:0] eb, input bit oka, input bit okb);
      @(negedge clk);
      in_vld = 0; in_last = 0;
      check_val("done_pulse", a_done, 1);
      check_val("crc_a", a_crc, ea);
      check_val("crc_b", b_crc, eb);
      check_val("check_ok_a", a_ok, oka);
      check_val("check_ok_b", b_ok, okb);
      check_val("no_bit_with_done", a_out_vld, 0);
   endtask

   task automatic idle_check();
      int hi;
      hi = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) check_val("done_one_cycle", a_done, 0);
         hi += int'(a_out_vld);
      end
      check_val("no_shift_in_check_mode", hi, 0);
      check_val("idle_in_rdy", a_in_rdy, 0);
   endtask

   task automatic collect(input logic [15:0] ea, input logic [15:0] eb,
                          input int stall_after, input int abort_at);
      int n, cyc, stalled;
      n = 0; cyc = 0; stalled = 0;
      while (n < 16 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            check_val("done_one_cycle", a_done, 0);
            check_val("first_bit_timing", a_out_vld, 1);
         end
         if (n == abort_at) begin
            start = 1; append = 1; out_rdy = 1;
            @(posedge clk);
            @(negedge clk);
            start = 0; out_rdy = 0;
            #1;
            check_val("abort_out_vld", a_out_vld, 0);
            check_val("abort_in_rdy", a_in_rdy, 1);
            return;
         end
         if (n == stall_after && stalled < 5) begin
            out_rdy = 0;
            stalled++;
            check_val("stall_bit", a_bit, ea[15-n]);
            check_val("stall_last", a_out_last, 0);
            check_val("stall_vld", a_out_vld, 1);
         end else begin
            out_rdy = 1;
            if (a_out_vld) begin
               check_val("bit_a", a_bit, ea[15-n]);
               check_val("bit_b", b_bit, eb[15-n]);
               check_val("out_last", a_out_last, n == 15);
               n++;
            end
         end
      end
      check_val("handshakes", n, 16);
      @(negedge clk);
      out_rdy = 0;
      check_val("vld_drop_after_last", a_out_vld, 0);
      check_val("idle_after_shift", a_in_rdy, 0);
   endtask

   task automatic run_c(input logic [7:0] msg[$], input int gap_pct, input logic [15:0] e);
      int dones, nbits, tries;
      bit sent;
      dones = 0;
      nbits = msg.size() * 8;
      @(negedge clk);
      c_start = 1; c_append = 0; c_vld = 0;
      @(negedge clk);
      c_start = 0;
      for (int i = 0; i < nbits; i++) begin
         sent = 0; tries = 0;
         while (!sent) begin
            if (i != 0 || tries != 0) @(negedge clk);
            dones += int'(c_done);
            c_vld = ($urandom_range(0, 99) >= gap_pct) || (tries >= 8);
            tries++;
            c_data = msg[i/8][7 - (i % 8)];
            c_last = (i == nbits - 1);
            #1;
            if (c_vld) begin
               check_val("c_in_rdy", c_in_rdy, 1);
               sent = 1;
            end
            @(posedge clk);
         end
      end
      @(negedge clk);
      c_vld = 0; c_last = 0;
      check_val("c_no_early_done", dones, 0);
      check_val("c_done", c_done, 1);
      check_val("c_crc", c_crc, e);
      check_val("c_check_ok", c_ok, e == 16'h0000);
      check_val("c_no_shift", c_out_vld, 0);
   endtask

   initial begin
      #2_000_000;
      n_err++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  std[$], chk[$], bad[$], m[$];
      logic [15:0] ea, eb;
      bit          app;
      int          len;

      rst = 1; start = 0; append = 0; in_vld = 0; in_last = 0; out_rdy = 0; data = '0;
      c_start = 0; c_append = 0; c_vld = 0; c_last = 0; c_out_rdy = 1; c_data = '0;
      #1;
      check_val("rst_in_rdy", a_in_rdy, 0);
      check_val("rst_out_vld", a_out_vld, 0);
      check_val("rst_crc_bit", a_bit, 0);
      check_val("rst_out_last", a_out_last, 0);
      check_val("rst_done", a_done, 0);
      check_val("rst_check_ok", a_ok, 0);
      check_val("rst_crc_value", a_crc, 0);
      repeat (2) @(negedge clk);
      rst = 0;

      std = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      chk = std;
      chk.push_back(8'h4C);
      chk.push_back(8'h06);
      bad = chk;
      bad[4] = 8'h34;

      // "123456789" with append, no stalls
      pulse_start(1, 0);
      feed(std, 0, 9);
      end_check(16'h4C06, 16'h31C3, 0, 0);
      collect(16'h4C06, 16'h31C3, -1, -1);

      // Same, with input gaps and a 5-cycle output stall after bit 3
      pulse_start(1, 0);
      feed(std, 30, 9);
      end_check(16'h4C06, 16'h31C3, 0, 0);
      collect(16'h4C06, 16'h31C3, 3, -1);

      // Check mode: message plus its CRC leaves a zero residue
      pulse_start(0, 0);
      feed(chk, 20, 11);
      eb = ref_rem(chk, 16'h1021, 16'h0000);
      end_check(16'h0000, eb, 1, eb == 16'h0000);
      idle_check();

      // Asynchronous reset in the middle of a frame
      pulse_start(1, 0);
      feed(std, 0, 4);
      @(negedge clk);
      in_vld = 1;
      rst = 1;
      #1;
      check_val("mid_rst_in_rdy", a_in_rdy, 0);
      check_val("mid_rst_out_vld", a_out_vld, 0);
      check_val("mid_rst_done", a_done, 0);
      check_val("mid_rst_check_ok", a_ok, 0);
      check_val("mid_rst_crc_a", a_crc, 0);
      check_val("mid_rst_crc_b", b_crc, 0);
      @(negedge clk);
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("post_rst_in_rdy", a_in_rdy, 0);
      end
      in_vld = 0;

      // Check mode with a corrupted byte
      pulse_start(0, 0);
      feed(bad, 0, 11);
      ea = ref_rem(bad, 16'hC867, 16'hFFFF);
      eb = ref_rem(bad, 16'h1021, 16'h0000);
      end_check(ea, eb, 0, eb == 16'h0000);
      idle_check();

      // Abort during serial output, then a fresh frame
      pulse_start(1, 0);
      feed(std, 0, 9);
      end_check(16'h4C06, 16'h31C3, 0, 0);
      collect(16'h4C06, 16'h31C3, -1, 7);
      feed(std, 0, 9);
      end_check(16'h4C06, 16'h31C3, 0, 0);
      collect(16'h4C06, 16'h31C3, -1, -1);

      // Abort mid-CALC with a same-cycle final beat that must be dropped
      m.delete();
      for (int k = 0; k < 5; k++) m.push_back(8'($urandom));
      pulse_start(1, 0);
      feed(m, 0, 3);
      pulse_start(1, 1);
      feed(std, 10, 9);
      end_check(16'h4C06, 16'h31C3, 0, 0);
      collect(16'h4C06, 16'h31C3, -1, -1);

      // Random frames
      for (int r = 0; r < 6; r++) begin
         len = $urandom_range(2, 10);
         app = 1'($urandom_range(0, 1));
         m.delete();
         for (int k = 0; k < len; k++) m.push_back(8'($urandom));
         if (!app) begin
            ea = ref_rem(m, 16'hC867, 16'hFFFF);
            m.push_back(ea[15:8]);
            m.push_back(ea[7:0]);
            if ($urandom_range(0, 1) == 1) begin
               len = $urandom_range(0, m.size() - 1);
               m[len] = m[len] ^ (8'h01 << $urandom_range(0, 7));
            end
         end
         ea = ref_rem(m, 16'hC867, 16'hFFFF);
         eb = ref_rem(m, 16'h1021, 16'h0000);
         pulse_start(app, 0);
         feed(m, 25, m.size());
         end_check(ea, eb, ea == 16'h0000, eb == 16'h0000);
         if (app) collect(ea, eb, $urandom_range(0, 15), -1);
         else     idle_check();
      end

      // Bit-serial instance
      run_c(std, 40, 16'h4C06);
      run_c(chk, 20, 16'h0000);
      m.delete();
      for (int k = 0; k < 4; k++) m.push_back(8'($urandom));
      run_c(m, 30, ref_rem(m, 16'hC867, 16'hFFFF));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
